// File: rtl/frequency_meter_if.sv
// ---------------------------------------------------------------------------
// frequency_meter_if
//
// Purpose: groups the measurement control input, the signal under test and
// the measurement results of frequency_meter into one bundle.
//
// Parameters:
//   WIDTH     - width of the period / high-time results
//
// Signals:
//   en        - measurement enable (level)
//   sig_in    - asynchronous signal being measured
//   period    - last measured period in clk cycles
//   valid     - one-cycle pulse when period (and high_time) update
//   locked    - high while back-to-back measurements are being produced
//   timeout   - one-cycle pulse when no rising edge arrived in counter range
//   high_time - high cycles of the last period (only with FREQ_METER_DUTY_EN)
//
// Modports:
//   master    - the user of the meter (drives en/sig_in, reads results)
//   slave     - the meter itself
// ---------------------------------------------------------------------------
interface frequency_meter_if #(
    parameter int WIDTH = 24
) ();

    logic             en;
    logic             sig_in;
    logic [WIDTH-1:0] period;
    logic             valid;
    logic             locked;
    logic             timeout;
`ifdef FREQ_METER_DUTY_EN
    logic [WIDTH-1:0] high_time;
`endif

    modport master (
        output en,
        output sig_in,
        input  period,
        input  valid,
        input  locked,
        input  timeout
`ifdef FREQ_METER_DUTY_EN
        ,
        input  high_time
`endif
    );

    modport slave (
        input  en,
        input  sig_in,
        output period,
        output valid,
        output locked,
        output timeout
`ifdef FREQ_METER_DUTY_EN
        ,
        output high_time
`endif
    );

endinterface

// File: rtl/frequency_meter.sv
// ---------------------------------------------------------------------------
// frequency_meter
//
// Purpose: measures the period (and optionally the high time) of a slow,
// asynchronous square wave in cycles of the system clock. The input is
// synchronized, rising edges are detected, and the number of clk cycles
// between consecutive rising edges is reported.
//
// Optional feature: define FREQ_METER_DUTY_EN to add the high_time result
// and the high-cycle counter behind it.
//
// Parameters:
//   WIDTH       - counter / result width; longest period is 2^WIDTH-1
//   SYNC_STAGES - synchronizer depth for sig_in (2 or more)
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - frequency_meter_if.slave: en, sig_in in; period, valid, locked,
//          timeout (and high_time) out
// ---------------------------------------------------------------------------
module frequency_meter #(
    parameter int WIDTH       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    frequency_meter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS
    } state_t;

    // Last count value before the counter would overflow the result range:
    // at cnt == 2^WIDTH-2 a rise would report 2^WIDTH-1, anything later
    // cannot be represented.
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] period_q;
    logic             valid_q;
    logic             locked_q;
    logic             timeout_q;

`ifdef FREQ_METER_DUTY_EN
    logic [WIDTH-1:0] hcnt;
    logic [WIDTH-1:0] high_q;
`endif

    // Synchronizer plus one extra flop for edge detection. The whole path
    // has a fixed latency, so it shifts both edges of every interval equally
    // and never changes a measured length.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
            s_d    <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;

    // Measurement FSM. The first rise after arming only starts the counter;
    // each later rise closes a period. A rise seen at count c means c+1
    // cycles have elapsed since the previous rise. Dropping en has priority
    // over everything and discards a half-finished period without valid.
    // hcnt restarts at one on a rise because the rise cycle itself is the
    // first high cycle of the new period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
`ifdef FREQ_METER_DUTY_EN
            hcnt      <= '0;
            high_q    <= '0;
`endif
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            if (!bus.en) begin
                state    <= IDLE;
                cnt      <= '0;
                locked_q <= 1'b0;
`ifdef FREQ_METER_DUTY_EN
                hcnt     <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        cnt      <= '0;
                        locked_q <= 1'b0;
`ifdef FREQ_METER_DUTY_EN
                        hcnt     <= '0;
`endif
                        state    <= ARM;
                    end
                    ARM: begin
                        if (rise) begin
                            cnt   <= '0;
`ifdef FREQ_METER_DUTY_EN
                            hcnt  <= CNT_ONE;
`endif
                            state <= MEAS;
                        end
                    end
                    MEAS: begin
                        if (rise) begin
                            period_q <= cnt + CNT_ONE;
                            valid_q  <= 1'b1;
                            locked_q <= 1'b1;
                            cnt      <= '0;
`ifdef FREQ_METER_DUTY_EN
                            high_q   <= hcnt;
                            hcnt     <= CNT_ONE;
`endif
                        end else if (cnt == CNT_LAST) begin
                            timeout_q <= 1'b1;
                            locked_q  <= 1'b0;
                            cnt       <= '0;
`ifdef FREQ_METER_DUTY_EN
                            hcnt      <= '0;
`endif
                            state     <= ARM;
                        end else begin
                            cnt  <= cnt + CNT_ONE;
`ifdef FREQ_METER_DUTY_EN
                            hcnt <= hcnt + {{(WIDTH-1){1'b0}}, s};
`endif
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.period  = period_q;
    assign bus.valid   = valid_q;
    assign bus.locked  = locked_q;
    assign bus.timeout = timeout_q;
`ifdef FREQ_METER_DUTY_EN
    assign bus.high_time = high_q;
`endif

endmodule

// File: tb/tb_frequency_meter.sv
// ---------------------------------------------------------------------------
// tb_frequency_meter
//
// Purpose: self-checking bench for frequency_meter (WIDTH=8 so that the
// counter-range timeout is reachable quickly). A behavioural model tracks
// the times of rising edges driven on sig_in and derives the expected
// period / high time / timeout / locked results from those times alone.
// ---------------------------------------------------------------------------
module tb_frequency_meter;

    localparam int W    = 8;
    localparam int SYNC = 2;

    typedef struct {
        int p;
        int h;
    } ev_t;

    logic clk;
    logic rst;

    frequency_meter_if #(.WIDTH(W)) bus ();

    frequency_meter #(
        .WIDTH       (W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  vectors     = 0;
    int  miscompares = 0;

    // Model state: time of the last rising edge seen while enabled, the
    // number of high cycles since it, and the results it implies.
    int  cyc           = 0;
    int  prev_rise     = 0;
    bit  have_prev     = 1'b0;
    bit  sig_prev      = 1'b0;
    bit  en_cur        = 1'b0;
    int  high_acc      = 0;
    int  exp_period    = 0;
    int  exp_high      = 0;
    bit  exp_locked    = 1'b0;
    int  exp_timeouts  = 0;
    ev_t exp_q[$];

    ev_t obs_q[$];
    int  obs_timeouts  = 0;
    int  obs_both      = 0;

    // Records every result pulse the meter produces.
    always @(negedge clk) begin
        ev_t e;
        if (bus.valid === 1'b1) begin
            e.p = int'(bus.period);
`ifdef FREQ_METER_DUTY_EN
            e.h = int'(bus.high_time);
`else
            e.h = 0;
`endif
            obs_q.push_back(e);
        end
        if (bus.timeout === 1'b1) obs_timeouts++;
        if (bus.valid === 1'b1 && bus.timeout === 1'b1) obs_both++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Drives sig_in for one clk cycle and updates the model.
    task automatic drive_bit(input bit b);
        ev_t e;
        if (b && !sig_prev && en_cur) begin
            if (have_prev) begin
                e.p = cyc - prev_rise;
                e.h = high_acc;
                exp_q.push_back(e);
                exp_period = e.p;
                exp_high   = e.h;
                exp_locked = 1'b1;
            end
            have_prev = 1'b1;
            prev_rise = cyc;
            high_acc  = 1;
        end else if (b) begin
            high_acc++;
        end
        bus.sig_in = b;
        sig_prev   = b;
        tick();
        cyc++;
        if (have_prev && (cyc - prev_rise) >= (1 << W)) begin
            exp_timeouts++;
            exp_locked = 1'b0;
            have_prev  = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int high, input int low);
        repeat (high) drive_bit(1'b1);
        repeat (low)  drive_bit(1'b0);
    endtask

    task automatic set_en(input bit b);
        bus.en = b;
        en_cur = b;
        if (!b) begin
            have_prev  = 1'b0;
            exp_locked = 1'b0;
        end
    endtask

    task automatic flush(input int n);
        repeat (n) drive_bit(sig_prev);
    endtask

    task automatic compare_all(input string name);
        flush(8);
        checkOutput({name, " valid count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checkOutput($sformatf("%s period[%0d]", name, i), obs_q[i].p, exp_q[i].p);
`ifdef FREQ_METER_DUTY_EN
            checkOutput($sformatf("%s high_time[%0d]", name, i), obs_q[i].h, exp_q[i].h);
`endif
        end
        obs_q.delete();
        exp_q.delete();
        checkOutput({name, " period reg"}, 32'(bus.period), exp_period);
`ifdef FREQ_METER_DUTY_EN
        checkOutput({name, " high_time reg"}, 32'(bus.high_time), exp_high);
`endif
        checkOutput({name, " locked"}, 32'(bus.locked), 32'(exp_locked));
        checkOutput({name, " timeout count"}, obs_timeouts, exp_timeouts);
        checkOutput({name, " valid+timeout overlap"}, obs_both, 0);
    endtask

    initial begin
        int hi;
        int lo;

        rst        = 1'b0;
        bus.en     = 1'b0;
        bus.sig_in = 1'b0;

        // Reset state
        repeat (3) tick();
        checkOutput("reset period", 32'(bus.period), 0);
        checkOutput("reset valid", 32'(bus.valid), 0);
        checkOutput("reset locked", 32'(bus.locked), 0);
        checkOutput("reset timeout", 32'(bus.timeout), 0);
`ifdef FREQ_METER_DUTY_EN
        checkOutput("reset high_time", 32'(bus.high_time), 0);
`endif
        rst = 1'b1;
        flush(2);

        // Period 10, 50 % duty, six periods
        $display("[TB] steady period 10");
        set_en(1'b1);
        flush(2);
        repeat (6) applyStimulus(5, 5);
        compare_all("p10");

        // Minimum period
        $display("[TB] minimum period 2");
        repeat (8) applyStimulus(1, 1);
        compare_all("p2");

        // Random periods
        $display("[TB] random periods");
        repeat (12) begin
            hi = int'($urandom_range(1, 8));
            lo = int'($urandom_range(1, 8));
            applyStimulus(hi, lo);
        end
        compare_all("random");

        // Counter-range timeout, then recovery with a 100-cycle period
        $display("[TB] timeout");
        applyStimulus(1, 0);
        flush(300);
        compare_all("timeout");
        applyStimulus(1, 99);
        applyStimulus(1, 99);
        compare_all("after timeout");

        // en dropped for three cycles in the low phase
        $display("[TB] enable drop");
        repeat (3) applyStimulus(5, 5);
        repeat (5) drive_bit(1'b1);
        drive_bit(1'b0);
        set_en(1'b0);
        repeat (3) drive_bit(1'b0);
        checkOutput("en drop locked", 32'(bus.locked), 32'(exp_locked));
        set_en(1'b1);
        drive_bit(1'b0);
        repeat (3) applyStimulus(5, 5);
        compare_all("en drop");

        // Asynchronous reset in the middle of a measurement
        $display("[TB] async reset");
        repeat (2) applyStimulus(5, 5);
        compare_all("pre reset");
        drive_bit(1'b0);
        drive_bit(1'b0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async reset period", 32'(bus.period), 0);
        checkOutput("async reset valid", 32'(bus.valid), 0);
        checkOutput("async reset locked", 32'(bus.locked), 0);
        checkOutput("async reset timeout", 32'(bus.timeout), 0);
`ifdef FREQ_METER_DUTY_EN
        checkOutput("async reset high_time", 32'(bus.high_time), 0);
`endif
        have_prev  = 1'b0;
        exp_locked = 1'b0;
        exp_period = 0;
        exp_high   = 0;
        drive_bit(1'b0);
        drive_bit(1'b0);
        rst = 1'b1;
        flush(2);
        repeat (4) applyStimulus(5, 5);
        compare_all("after reset");

        // Period change from 10 to 7 with 3 high cycles
        $display("[TB] period change");
        repeat (2) applyStimulus(5, 5);
        repeat (3) applyStimulus(3, 4);
        compare_all("p7");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
